// File: rtl/amp_power_sequencer.sv
// Pop-free power sequencer for the class-D output stage: orders enable, mute
// release and gain ramps around run requests, lock state and hard faults.
module amp_power_sequencer #(
    parameter int GAIN_W     = 8,
    parameter int CNT_W      = 8,
    parameter int EN_DELAY   = 64,
    parameter int MUTE_DELAY = 16,
    parameter int RAMP_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run_req,
    input  logic              audio_locked,
    input  logic              fault,
    input  logic [GAIN_W-1:0] target_gain,
    output logic              nenable_out,
    output logic              nmute_out,
    output logic              pwm_run,
    output logic [GAIN_W-1:0] gain,
    output logic [2:0]        state,
    output logic              fault_flag
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWR_UP    = 3'd1,
        S_UNMUTE    = 3'd2,
        S_RAMP_UP   = 3'd3,
        S_PLAY      = 3'd4,
        S_RAMP_DN   = 3'd5,
        S_MUTE_WAIT = 3'd6,
        S_PWR_DN    = 3'd7
    } state_t;

    localparam int EN_LD_I   = (EN_DELAY   < 1) ? 1 : EN_DELAY;
    localparam int MUTE_LD_I = (MUTE_DELAY < 1) ? 1 : MUTE_DELAY;
    localparam logic [CNT_W-1:0]  EN_LD   = CNT_W'(EN_LD_I);
    localparam logic [CNT_W-1:0]  MUTE_LD = CNT_W'(MUTE_LD_I);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [GAIN_W:0]   STEP_X  = (GAIN_W+1)'(RAMP_STEP);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_dec;
    logic [GAIN_W-1:0]   r_gain, w_gain_nxt;
    logic                r_nenable, r_nmute, r_pwm_run, r_fault_flag;
    logic                w_nenable_nxt, w_nmute_nxt, w_pwm_nxt, w_ff_nxt;
    logic                w_go, w_expire;
    logic [GAIN_W:0]     w_sum, w_gap;
    logic [GAIN_W-1:0]   w_inc, w_up, w_dn, w_toward;

    // Gain arithmetic is one bit wider so increments saturate instead of wrapping.
    always_comb begin
        w_sum = {1'b0, r_gain} + STEP_X;
        w_inc = w_sum[GAIN_W] ? '1 : w_sum[GAIN_W-1:0];
        w_up  = (w_inc > target_gain) ? target_gain : w_inc;
        w_gap = {1'b0, r_gain} - {1'b0, target_gain};
        w_dn  = ({1'b0, r_gain} <= STEP_X) ? '0 : r_gain - STEP_X[GAIN_W-1:0];
        if (r_gain < target_gain)
            w_toward = w_up;
        else if (w_gap <= STEP_X)
            w_toward = target_gain;
        else
            w_toward = r_gain - STEP_X[GAIN_W-1:0];
    end

    always_comb begin
        w_go        = run_req & audio_locked & ~r_fault_flag;
        w_expire    = tick & (r_cnt <= CNT_ONE);
        w_cnt_dec   = (tick && r_cnt != '0) ? r_cnt - CNT_ONE : r_cnt;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gain_nxt  = r_gain;
        w_ff_nxt    = r_fault_flag & (run_req | fault);

        if (fault) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
            w_gain_nxt  = '0;
            w_ff_nxt    = 1'b1;
        end else begin
            // ~go is tested before any tick work so a stop never also moves gain.
            case (r_state)
                S_OFF: begin
                    if (w_go) begin
                        w_state_nxt = S_PWR_UP;
                        w_cnt_nxt   = EN_LD;
                    end
                end
                S_PWR_UP: begin
                    if (!w_go) begin
                        w_state_nxt = S_PWR_DN;
                        w_cnt_nxt   = EN_LD;
                    end else if (w_expire) begin
                        w_state_nxt = S_UNMUTE;
                        w_cnt_nxt   = MUTE_LD;
                    end else begin
                        w_cnt_nxt   = w_cnt_dec;
                    end
                end
                S_UNMUTE: begin
                    if (!w_go) begin
                        w_state_nxt = S_MUTE_WAIT;
                        w_cnt_nxt   = MUTE_LD;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                        if (w_expire) w_state_nxt = S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (!w_go) begin
                        w_state_nxt = S_RAMP_DN;
                    end else begin
                        w_gain_nxt = tick ? w_up : r_gain;
                        if (w_gain_nxt == target_gain) w_state_nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!w_go)     w_state_nxt = S_RAMP_DN;
                    else if (tick) w_gain_nxt  = w_toward;
                end
                S_RAMP_DN: begin
                    if (w_go) begin
                        w_state_nxt = S_RAMP_UP;
                    end else begin
                        w_gain_nxt = tick ? w_dn : r_gain;
                        if (w_gain_nxt == '0) begin
                            w_state_nxt = S_MUTE_WAIT;
                            w_cnt_nxt   = MUTE_LD;
                        end
                    end
                end
                S_MUTE_WAIT: begin
                    w_cnt_nxt = w_cnt_dec;
                    if (w_expire) begin
                        w_state_nxt = S_PWR_DN;
                        w_cnt_nxt   = EN_LD;
                    end
                end
                S_PWR_DN: begin
                    w_cnt_nxt = w_cnt_dec;
                    if (w_expire) w_state_nxt = S_OFF;
                end
                default: w_state_nxt = S_OFF;
            endcase
        end

        w_nenable_nxt = (w_state_nxt == S_OFF);
        w_pwm_nxt     = ~w_nenable_nxt;
        w_nmute_nxt   = (w_state_nxt inside {S_UNMUTE, S_RAMP_UP, S_PLAY, S_RAMP_DN});
        if (!(w_state_nxt inside {S_RAMP_UP, S_PLAY, S_RAMP_DN})) w_gain_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_gain       <= '0;
            r_nenable    <= 1'b1;
            r_nmute      <= 1'b0;
            r_pwm_run    <= 1'b0;
            r_fault_flag <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gain       <= w_gain_nxt;
            r_nenable    <= w_nenable_nxt;
            r_nmute      <= w_nmute_nxt;
            r_pwm_run    <= w_pwm_nxt;
            r_fault_flag <= w_ff_nxt;
        end
    end

    assign nenable_out = r_nenable;
    assign nmute_out   = r_nmute;
    assign pwm_run     = r_pwm_run;
    assign gain        = r_gain;
    assign state       = r_state;
    assign fault_flag  = r_fault_flag;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Bench for amp_power_sequencer: two instances (unit step and step 16) checked
// every cycle against a behavioural model, plus directed timing/value checks.
module tb_amp_power_sequencer;

    localparam int P_OFF = 0, P_PWR_UP = 1, P_UNMUTE = 2, P_RAMP_UP = 3;
    localparam int P_PLAY = 4, P_RAMP_DN = 5, P_MUTE_WAIT = 6, P_PWR_DN = 7;

    logic       clk = 1'b0;
    logic       reset, tick;
    logic       a_run, a_lock, a_fault, b_run, b_lock, b_fault;
    logic [7:0] a_tgt, b_tgt;
    logic       a_nen, a_nmute, a_pwm, a_ff, b_nen, b_nmute, b_pwm, b_ff;
    logic [7:0] a_gain, b_gain;
    logic [2:0] a_state, b_state;

    int  n_cmp = 0, n_bad = 0;
    int  tick_total = 0;
    bit  cmp_on = 0;
    bit  nm_lo, nm_hi;
    int  gq[$];
    int  gmax_seen;

    always #5 clk = ~clk;

    amp_power_sequencer #(.GAIN_W(8), .CNT_W(8), .EN_DELAY(4), .MUTE_DELAY(2), .RAMP_STEP(1)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .run_req(a_run), .audio_locked(a_lock),
        .fault(a_fault), .target_gain(a_tgt), .nenable_out(a_nen), .nmute_out(a_nmute),
        .pwm_run(a_pwm), .gain(a_gain), .state(a_state), .fault_flag(a_ff));

    amp_power_sequencer #(.GAIN_W(8), .CNT_W(8), .EN_DELAY(4), .MUTE_DELAY(2), .RAMP_STEP(16)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .run_req(b_run), .audio_locked(b_lock),
        .fault(b_fault), .target_gain(b_tgt), .nenable_out(b_nen), .nmute_out(b_nmute),
        .pwm_run(b_pwm), .gain(b_gain), .state(b_state), .fault_flag(b_ff));

    typedef struct packed {
        int st; int cnt; int gain;
        bit nen; bit nmute; bit pwm; bit ff;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int imin(input int x, input int y); return (x < y) ? x : y; endfunction
    function automatic int imax(input int x, input int y); return (x > y) ? x : y; endfunction

    // One clock of the sequencing rules, in plain integer arithmetic.
    function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit tk, input bit rq,
                                   input bit lk, input bit flt, input int tgt, input int en_d,
                                   input int mu_d, input int stp, input int gmax);
        mdl_t n;
        int   ld_en, ld_mu;
        bit   go, expire;
        ld_en  = imax(en_d, 1);
        ld_mu  = imax(mu_d, 1);
        go     = rq && lk && !m.ff;
        expire = tk && (m.cnt <= 1);
        n      = m;
        if (rst || flt) begin
            n.st = P_OFF; n.cnt = 0; n.gain = 0; n.ff = !rst;
        end else begin
            if (!rq) n.ff = 1'b0;
            if (m.st == P_OFF) begin
                if (go) begin n.st = P_PWR_UP; n.cnt = ld_en; end
            end else if (m.st == P_PWR_UP || m.st == P_UNMUTE) begin
                if (!go) begin
                    n.st  = (m.st == P_PWR_UP) ? P_PWR_DN : P_MUTE_WAIT;
                    n.cnt = (m.st == P_PWR_UP) ? ld_en : ld_mu;
                end else if (expire) begin
                    n.st  = m.st + 1;
                    n.cnt = (m.st == P_PWR_UP) ? ld_mu : 0;
                end else if (tk) n.cnt = m.cnt - 1;
            end else if (m.st == P_RAMP_UP) begin
                if (!go) n.st = P_RAMP_DN;
                else begin
                    if (tk) n.gain = imin(imin(m.gain + stp, gmax), tgt);
                    if (n.gain == tgt) n.st = P_PLAY;
                end
            end else if (m.st == P_PLAY) begin
                if (!go) n.st = P_RAMP_DN;
                else if (tk) n.gain = (m.gain < tgt) ? imin(m.gain + stp, tgt) : imax(m.gain - stp, tgt);
            end else if (m.st == P_RAMP_DN) begin
                if (go) n.st = P_RAMP_UP;
                else begin
                    if (tk) n.gain = imax(m.gain - stp, 0);
                    if (n.gain == 0) begin n.st = P_MUTE_WAIT; n.cnt = ld_mu; end
                end
            end else begin
                if (expire) begin
                    n.st  = (m.st == P_MUTE_WAIT) ? P_PWR_DN : P_OFF;
                    n.cnt = (m.st == P_MUTE_WAIT) ? ld_en : 0;
                end else if (tk) n.cnt = m.cnt - 1;
            end
        end
        n.nen   = (n.st == P_OFF);
        n.pwm   = (n.st != P_OFF);
        n.nmute = (n.st >= P_UNMUTE && n.st <= P_RAMP_DN);
        if (!(n.st >= P_RAMP_UP && n.st <= P_RAMP_DN)) n.gain = 0;
        return n;
    endfunction

    function automatic int mvec(input mdl_t m);
        return {17'd0, 3'(m.st), m.nen, m.nmute, m.pwm, m.ff, 8'(m.gain)};
    endfunction

    function automatic int dvec(input logic [2:0] s, input logic ne, input logic nm,
                                input logic pw, input logic ff, input logic [7:0] g);
        return {17'd0, s, ne, nm, pw, ff, g};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ma = mstep(ma, reset, tick, a_run, a_lock, a_fault, int'(a_tgt), 4, 2, 1, 255);
        mb = mstep(mb, reset, tick, b_run, b_lock, b_fault, int'(b_tgt), 4, 2, 16, 255);
        if (tick) tick_total++;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("A_cycle", dvec(a_state, a_nen, a_nmute, a_pwm, a_ff, a_gain), mvec(ma));
            check("B_cycle", dvec(b_state, b_nen, b_nmute, b_pwm, b_ff, b_gain), mvec(mb));
        end
    end

    initial begin
        int ph = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            ph   = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    // what: 0=state 1=gain 2=nmute 3=nenable (instance A)
    task automatic wait_a(input int what, input int val, input int budget, input string nm);
        bit hit = 0;
        nm_lo = 0; nm_hi = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_nmute) nm_hi = 1; else nm_lo = 1;
            case (what)
                0: hit = (int'(a_state) == val);
                1: hit = (int'(a_gain) == val);
                2: hit = (int'(a_nmute) == val);
                default: hit = (int'(a_nen) == val);
            endcase
            if (hit) break;
        end
        check({nm, "_reached"}, int'(hit), 1);
    endtask

    task automatic watch_b(input int stop_gain, input int budget, input string nm);
        bit hit = 0;
        int last;
        gq.delete();
        last = int'(b_gain);
        gmax_seen = last;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(b_gain) != last) begin
                last = int'(b_gain);
                gq.push_back(last);
            end
            if (last > gmax_seen) gmax_seen = last;
            if (int'(b_state) == P_PLAY && last == stop_gain) begin hit = 1; break; end
        end
        check({nm, "_reached"}, int'(hit), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, prev;
        reset = 1'b1;
        a_run = 0; a_lock = 1; a_fault = 0; a_tgt = 8'd5;
        b_run = 0; b_lock = 1; b_fault = 0; b_tgt = 8'd250;
        repeat (3) @(negedge clk);
        cmp_on = 1;
        check("reset_vec", dvec(a_state, a_nen, a_nmute, a_pwm, a_ff, a_gain), 32'h0800);
        reset = 1'b0;
        @(negedge clk);

        // Nominal start
        a_run = 1;
        @(negedge clk);
        check("nen_fall_1cyc", int'(a_nen), 0);
        check("pwr_up_state", int'(a_state), P_PWR_UP);
        base = tick_total;
        wait_a(2, 1, 100, "nmute_rise");
        check("nmute_rise_ticks", tick_total - base, 4);
        wait_a(0, P_PLAY, 200, "play");
        check("play_ticks", tick_total - base, 11);
        check("play_gain", int'(a_gain), 5);

        // Stop from PLAY
        a_run = 0;
        @(negedge clk);
        check("rampdn_entry", int'(a_state), P_RAMP_DN);
        base = tick_total;
        wait_a(2, 0, 100, "nmute_fall");
        check("nmute_fall_ticks", tick_total - base, 5);
        check("mute_wait_state", int'(a_state), P_MUTE_WAIT);
        check("mute_wait_gain", int'(a_gain), 0);
        wait_a(3, 1, 100, "nen_rise");
        check("nen_rise_ticks", tick_total - base, 11);
        check("off_state", int'(a_state), P_OFF);

        // Lock loss during PWR_UP with two ticks left
        a_run = 1;
        @(negedge clk);
        base = tick_total;
        for (int i = 0; i < 100 && (tick_total - base) < 2; i++) @(negedge clk);
        check("lockloss_prep_ticks", tick_total - base, 2);
        a_lock = 0;
        @(negedge clk);
        check("lockloss_pwr_dn", int'(a_state), P_PWR_DN);
        base = tick_total;
        wait_a(0, P_OFF, 100, "lockloss_off");
        check("lockloss_off_ticks", tick_total - base, 4);
        check("lockloss_no_unmute", int'(nm_hi), 0);

        // Re-request during RAMP_DN at gain 3
        a_lock = 1;
        wait_a(0, P_PLAY, 300, "replay");
        a_run = 0;
        wait_a(1, 3, 100, "rampdn_gain3");
        a_run = 1;
        @(negedge clk);
        check("rereq_state", int'(a_state), P_RAMP_UP);
        check("rereq_gain", int'(a_gain), 3);
        base = tick_total;
        wait_a(0, P_PLAY, 100, "rereq_play");
        check("rereq_ticks", tick_total - base, 2);
        check("rereq_gain_final", int'(a_gain), 5);
        check("rereq_nmute_held", int'(nm_lo), 0);

        // One-cycle fault in PLAY
        a_fault = 1;
        @(negedge clk);
        a_fault = 0;
        @(negedge clk);
        check("fault_vec", dvec(a_state, a_nen, a_nmute, a_pwm, a_ff, a_gain), 32'h0900);
        repeat (5) @(negedge clk);
        check("fault_sticky", int'(a_ff), 1);
        check("fault_stays_off", int'(a_state), P_OFF);
        a_run = 0;
        @(negedge clk);
        check("fault_clear", int'(a_ff), 0);

        // Saturation with step 16
        b_run = 1;
        watch_b(250, 400, "b_up");
        check("b_up_count", gq.size(), 16);
        check("b_up_m2", gq[gq.size() - 3], 224);
        check("b_up_m1", gq[gq.size() - 2], 240);
        check("b_up_last", gq[gq.size() - 1], 250);
        check("b_no_overshoot", gmax_seen, 250);
        b_tgt = 8'd10;
        watch_b(10, 400, "b_down");
        check("b_down_count", gq.size(), 15);
        prev = 250;
        foreach (gq[i]) begin
            check("b_down_step", prev - gq[i], 16);
            prev = gq[i];
        end
        b_tgt = 8'd255;
        watch_b(255, 400, "b_top");
        check("b_top_count", gq.size(), 16);
        check("b_top_prev", gq[gq.size() - 2], 250);
        check("b_top_gain", int'(b_gain), 255);
        b_run = 0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
